mult_arbiter: RTL and testbench
===============================

# mult_arbiter

Sequenced, round-robin arbiter that shares one instance of the combinational Q-format `multiplier` (13-bit signed number in [15:3], 3-bit scale factor in [2:0]) among NUM_REQ requesters in the ODE solver datapath. It accepts one operand pair at a time over a valid/ready handshake and registers the operands ahead of the multiplier. It captures the product into a result register and returns it to the granting requester over a per-requester valid/ready response handshake. Stage units (derivative evaluation, step-size scaling, accumulators) connect here instead of instantiating their own multipliers.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- WIDTH, 16, operand/result width; fixed at 16 for the Q format
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  NUM_REQ  requester i has an operand pair pending
- req_ready  out  NUM_REQ  one-hot; operand pair of requester i accepted this cycle
- req_a  in  NUM_REQ*WIDTH  first operands, requester i at [i*16 +: 16]
- req_b  in  NUM_REQ*WIDTH  second operands, same packing
- rsp_valid  out  NUM_REQ  one-hot; product for requester i available
- rsp_ready  in  NUM_REQ  requester i takes its product
- rsp_data  out  WIDTH  product, valid while any rsp_valid bit is set
- busy  out  1  high in CALC and RESP

## Operation
- FSM states: IDLE, CALC, RESP. Reset state is IDLE.
- **IDLE**
  - Grant the first set req_valid bit, searching from ptr upward modulo NUM_REQ.
  - req_ready[grant] is asserted combinationally; no other bit is set. req_ready is all-zero outside IDLE.
  - On valid&ready, latch req_a/req_b of the grantee into op_a/op_b and latch the grant index into gnt. Go to CALC.
  - With no valid bits set, stay in IDLE.
- **CALC**
  - The multiplier sees op_a/op_b.
  - res captures the multiplier output.
  - Go to RESP.
- **RESP**
  - rsp_valid[gnt]=1 and rsp_data=res, both held stable until rsp_ready[gnt].
  - On handshake, set ptr = (gnt+1) mod NUM_REQ (wrap from NUM_REQ-1 to 0) and go to IDLE.
  - rsp_ready bits for other requesters are ignored.
- **Arithmetic** (all of it inside `multiplier`)
  - The two numbers are multiplied. The scale factors are added.
  - A scale sum above 7 gives output scale 7, and the product is shifted right arithmetically by (sum-7).
  - The low 13 bits of the product are kept; no saturation.
  - The arbiter does not alter operands or results.
- **Requester rules**
  - A requester must hold req_a/req_b stable while req_valid is high and req_ready is low.
  - Dropping req_valid before acceptance is legal; that requester then drops out of arbitration.

## Timing
- Reset values:
  - req_ready=0, rsp_valid=0, rsp_data=0, busy=0
  - ptr=0, gnt=0, op_a=op_b=res=0
- Latency: accepted in cycle N, so rsp_valid rises in cycle N+2.
- Minimum issue interval is 3 cycles per operation, reached when rsp_ready is held high.
- rsp_ready high in the same cycle rsp_valid rises completes the response that cycle. IDLE is entered at N+3.
- A requester may present a new req_valid while its own response is pending. It is not served until FSM returns to IDLE; it then competes normally from the advanced ptr.
- Simultaneous requests from all NUM_REQ are served in rotating order starting at ptr. No requester waits more than NUM_REQ grants.
- Reset asserted mid-operation: outputs clear immediately (asynchronously). The pending operation and response are discarded and ptr returns to 0. The first grant after release goes to the lowest-index valid requester.

## Structure
- Shared package (`ode_pkg`):
  - Q-format constants: WIDTH=16, NUM_BITS=13, SCALE_BITS=3, SCALE_MAX=7.
  - FSM state enum {IDLE, CALC, RESP}.
- Sub-module: one instance of the existing `multiplier`, driven by op_a/op_b.
- Round-robin priority search stays inline; no separate arbiter module.

## Test plan
- **Single request.** Requester 0 sends a=16'h0019 (1.5, scale 1) and b=16'h0010 (2.0).
  - Required: req_ready[0] in the accept cycle, rsp_valid[0] 2 cycles later, rsp_data=16'h0031 (3.0).
- **Signed product.** Requester 2 sends a=16'hFFF8 (-1) and b=16'h0019.
  - Required: rsp_data=16'hFFE9 (-1.5).
- **Scale saturation.** a=16'h0047 (number 8, scale 7) and b=16'h0022 (number 4, scale 2).
  - Required: shift by 2, rsp_data=16'h0047.
- **Round robin with wrap.** All 4 req_valid held high from reset, rsp_ready held high.
  - Required grant order: 0, 1, 2, 3, 0, each 3 cycles apart.
  - req_ready is never multi-hot.
- **Back-pressure.** rsp_ready[1] held low for 5 cycles.
  - Required: rsp_valid[1] and rsp_data stay stable, req_ready stays 0, busy stays 1.
  - The response completes on the cycle rsp_ready[1] rises.
- **Reset mid-operation.** Assert rst during CALC with requester 3 granted.
  - Required: all outputs are 0 immediately and no response is ever issued for requester 3.
  - After release, with requesters 1 and 3 valid, requester 1 is granted first.

Source files
------------

// File: rtl/mult_arbiter_pkg.sv
// Shared constants and types for the ODE solver multiply path.
package ode_pkg;

  // Q format: 13-bit signed number in [15:3], 3-bit scale factor in [2:0].
  localparam int WIDTH      = 16;
  localparam int NUM_BITS   = 13;
  localparam int SCALE_BITS = 3;
  localparam int SCALE_MAX  = 7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/mult_arbiter_if.sv
// Request/response bundle between the stage units and the shared multiplier.
// Handshake: a transfer happens on a rising clk edge where valid and ready are
// both high; the sender holds its payload stable while valid is high and
// ready is low. req_* flows requester -> arbiter, rsp_* flows arbiter ->
// requester, and each requester owns bit i of every per-requester vector.
interface mult_arbiter_if #(
  parameter int NUM_REQ = 4
) ();
  import ode_pkg::*;

  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*WIDTH-1:0] req_a;
  logic [NUM_REQ*WIDTH-1:0] req_b;
  logic [NUM_REQ-1:0]       rsp_valid;
  logic [NUM_REQ-1:0]       rsp_ready;
  logic [WIDTH-1:0]         rsp_data;
  logic                     busy;

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_data, busy
  );

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, busy
  );

endinterface

// File: rtl/mult_arbiter_multiplier.sv
// Combinational Q-format multiplier: numbers multiply, scales add, and a
// scale sum above SCALE_MAX is folded back by an arithmetic right shift.
// Only the low NUM_BITS of the product survive; there is no saturation.
module multiplier
  import ode_pkg::*;
(
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] p_o
);

  logic signed [NUM_BITS-1:0]   num_a;
  logic signed [NUM_BITS-1:0]   num_b;
  logic signed [2*NUM_BITS-1:0] prod;
  logic signed [2*NUM_BITS-1:0] prod_adj;
  logic [SCALE_BITS:0]          scale_sum;
  logic [SCALE_BITS-1:0]        scale_out;

  // Multiply, then renormalise the scale into its 3-bit field.
  always_comb begin
    num_a     = a_i[WIDTH-1:SCALE_BITS];
    num_b     = b_i[WIDTH-1:SCALE_BITS];
    prod      = num_a * num_b;
    scale_sum = {1'b0, a_i[SCALE_BITS-1:0]} + {1'b0, b_i[SCALE_BITS-1:0]};
    prod_adj  = prod;
    scale_out = scale_sum[SCALE_BITS-1:0];
    if (scale_sum > (SCALE_BITS+1)'(SCALE_MAX)) begin
      prod_adj  = prod >>> (scale_sum - (SCALE_BITS+1)'(SCALE_MAX));
      scale_out = SCALE_BITS'(SCALE_MAX);
    end
    p_o = {prod_adj[NUM_BITS-1:0], scale_out};
  end

endmodule

// File: rtl/mult_arbiter.sv
// Round-robin arbiter that time-shares one Q-format multiplier. One operation
// is in flight at a time: IDLE grants and registers operands, CALC captures
// the product, RESP holds the result until the granted requester takes it.
module mult_arbiter
  import ode_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  mult_arbiter_if.slave        bus,
  output state_e               state_o
);

  localparam int IW = $clog2(NUM_REQ);

  state_e             state_q;
  logic [IW-1:0]      ptr_q;
  logic [IW-1:0]      gnt_q;
  logic [WIDTH-1:0]   op_a_q;
  logic [WIDTH-1:0]   op_b_q;
  logic [WIDTH-1:0]   res_q;
  logic [NUM_REQ-1:0] rsp_valid_q;

  logic [IW-1:0]      gnt_d;
  logic               gnt_vld_d;
  logic [WIDTH-1:0]   mul_p;

  // Requester index k positions above ptr, wrapping at NUM_REQ.
  function automatic logic [IW-1:0] rr_idx(input logic [IW-1:0] base, input int k);
    int idx;
    idx = int'(base) + k;
    if (idx >= NUM_REQ) idx = idx - NUM_REQ;
    return IW'(idx);
  endfunction

  // Priority search from ptr upward; scanning downward lets the nearest hit win.
  always_comb begin
    gnt_d     = ptr_q;
    gnt_vld_d = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (bus.req_valid[rr_idx(ptr_q, k)]) begin
        gnt_d     = rr_idx(ptr_q, k);
        gnt_vld_d = 1'b1;
      end
    end
  end

  // Ready is offered only to the current winner and only while IDLE.
  always_comb begin
    bus.req_ready = '0;
    if (state_q == IDLE && gnt_vld_d) bus.req_ready[gnt_d] = 1'b1;
  end

  multiplier u_mul (
    .a_i (op_a_q),
    .b_i (op_b_q),
    .p_o (mul_p)
  );

  // Sequencer: grant/latch, compute, then hold the response until taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      gnt_q       <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      res_q       <= '0;
      rsp_valid_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (gnt_vld_d) begin
            op_a_q  <= bus.req_a[gnt_d*WIDTH +: WIDTH];
            op_b_q  <= bus.req_b[gnt_d*WIDTH +: WIDTH];
            gnt_q   <= gnt_d;
            state_q <= CALC;
          end
        end
        CALC: begin
          res_q       <= mul_p;
          rsp_valid_q <= NUM_REQ'(1) << gnt_q;
          state_q     <= RESP;
        end
        RESP: begin
          // Only the granted requester's ready bit can close the response.
          if (bus.rsp_ready[gnt_q]) begin
            rsp_valid_q <= '0;
            ptr_q       <= (gnt_q == IW'(NUM_REQ - 1)) ? '0 : gnt_q + 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = res_q;
  assign bus.busy      = (state_q != IDLE);
  assign state_o       = state_q;

endmodule

// File: tb/tb_mult_arbiter.sv
// Bench for mult_arbiter: vector table, back-pressure, round robin, reset
// abort and randomized traffic against a behavioural reference model.
module tb_mult_arbiter;
  import ode_pkg::*;

  localparam int N = 4;

  // ---------------- clock / reset ----------------
  logic   clk = 1'b0;
  logic   rst;
  state_e state_dbg;
  int     cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  mult_arbiter_if #(.NUM_REQ(N)) bus ();

  mult_arbiter #(.NUM_REQ(N)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .state_o (state_dbg)
  );

  logic [15:0]  a_arr [N];
  logic [15:0]  b_arr [N];
  logic [N-1:0] valid_drv;
  logic [N-1:0] rdy_drv;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      bus.req_a[i*16 +: 16] = a_arr[i];
      bus.req_b[i*16 +: 16] = b_arr[i];
    end
    bus.req_valid = valid_drv;
    bus.rsp_ready = rdy_drv;
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  int m_ptr  = 0;
  logic watch3 = 1'b0;
  logic [15:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at cycle %0d", name, act, req, cyc);
    end
  endtask

  // Continuous one-hot and abort watch, sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if ($countones(bus.req_ready) > 1 || $countones(bus.rsp_valid) > 1) begin
        errors++;
        $display("FAIL onehot req_ready=%b rsp_valid=%b at cycle %0d", bus.req_ready, bus.rsp_valid, cyc);
      end
      if (watch3) begin
        checks++;
        if (bus.rsp_valid[3]) begin
          errors++;
          $display("FAIL aborted_rsp3 actual=%b required=0 at cycle %0d", bus.rsp_valid[3], cyc);
        end
      end
    end
  end

  // ---------------- reference model ----------------
  function automatic logic [15:0] ref_mul(input logic [15:0] a, input logic [15:0] b);
    int na, nb, p, s;
    logic [31:0] pv, sv;
    na = int'($signed(a[15:3]));
    nb = int'($signed(b[15:3]));
    p  = na * nb;
    s  = int'(a[2:0]) + int'(b[2:0]);
    if (s > 7) begin
      p = p >>> (s - 7);
      s = 7;
    end
    pv = p;
    sv = s;
    return {pv[12:0], sv[2:0]};
  endfunction

  function automatic int ref_grant(input logic [N-1:0] mask, input int ptr);
    for (int k = 0; k < N; k++) begin
      if (mask[(ptr + k) % N]) return (ptr + k) % N;
    end
    return 0;
  endfunction

  // ---------------- driver ----------------
  int last_acc = -100;

  // One full operation; entered and left one time unit after a rising edge
  // with the DUT in IDLE. keep=1 leaves the grantee's valid asserted.
  task automatic do_op(input logic [N-1:0] mask, input int delay, input logic keep,
                       input logic use_exp, input logic [15:0] exp_in, input logic chk_gap);
    int g;
    logic [15:0] e;
    logic [15:0] got;
    g = ref_grant(mask, m_ptr);
    exp_q.push_back(use_exp ? exp_in : ref_mul(a_arr[g], b_arr[g]));
    valid_drv = mask;
    rdy_drv   = (delay == 0) ? '1 : '0;
    #1;
    chk("grant", {28'd0, bus.req_ready}, 32'(1) << g);
    chk("busy_idle", {31'd0, bus.busy}, 0);
    if (chk_gap) chk("issue_gap", cyc - last_acc, 3);
    last_acc = cyc;
    @(posedge clk); #1;
    if (!keep) valid_drv[g] = 1'b0;
    chk("calc_req_ready", {28'd0, bus.req_ready}, 0);
    chk("calc_rsp_valid", {28'd0, bus.rsp_valid}, 0);
    chk("calc_busy", {31'd0, bus.busy}, 1);
    @(posedge clk); #1;
    e = exp_q.pop_front();
    chk("rsp_valid", {28'd0, bus.rsp_valid}, 32'(1) << g);
    chk("rsp_data", {16'd0, bus.rsp_data}, {16'd0, e});
    got = bus.rsp_data;
    if (delay > 0) begin
      rdy_drv = ~(N'(1) << g);
      repeat (delay) begin
        @(posedge clk); #1;
        chk("hold_rsp_valid", {28'd0, bus.rsp_valid}, 32'(1) << g);
        chk("hold_rsp_data", {16'd0, bus.rsp_data}, {16'd0, got});
        chk("hold_req_ready", {28'd0, bus.req_ready}, 0);
        chk("hold_busy", {31'd0, bus.busy}, 1);
      end
      rdy_drv[g] = 1'b1;
    end
    @(posedge clk); #1;
    rdy_drv = '0;
    chk("done_rsp_valid", {28'd0, bus.rsp_valid}, 0);
    chk("done_busy", {31'd0, bus.busy}, 0);
    m_ptr = (g + 1) % N;
  endtask

  task automatic check_cleared(input string tag);
    chk({tag, "_req_ready"}, {28'd0, bus.req_ready}, 0);
    chk({tag, "_rsp_valid"}, {28'd0, bus.rsp_valid}, 0);
    chk({tag, "_rsp_data"}, {16'd0, bus.rsp_data}, 0);
    chk({tag, "_busy"}, {31'd0, bus.busy}, 0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int          idx;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs [10];

  initial begin
    vecs[0] = '{0, 16'h0019, 16'h0010, 16'h0031};  // 1.5 * 2.0 = 3.0
    vecs[1] = '{2, 16'hFFF8, 16'h0019, 16'hFFE9};  // -1 * 1.5 = -1.5
    vecs[2] = '{1, 16'h0047, 16'h0022, 16'h0047};  // scale sum 9 -> shift 2
    vecs[3] = '{3, 16'h0008, 16'h0008, 16'h0008};  // 1 * 1
    vecs[4] = '{0, 16'hFFF8, 16'hFFF8, 16'h0008};  // -1 * -1
    vecs[5] = '{2, 16'h7FF8, 16'h0010, 16'hFFF0};  // 4095*2 wraps to -2
    vecs[6] = '{1, 16'h000F, 16'h000F, 16'h0007};  // scale sum 14, 1>>7 = 0
    vecs[7] = '{3, 16'hFFFF, 16'h000F, 16'hFFFF};  // -1>>>7 stays -1
    vecs[8] = '{1, 16'h0000, 16'h7FFF, 16'h0007};  // zero, scale sum 7
    vecs[9] = '{0, 16'h0018, 16'hFFE8, 16'hFFB8};  // 3 * -3 = -9

    rst       = 1'b1;
    valid_drv = '0;
    rdy_drv   = '0;
    for (int i = 0; i < N; i++) begin
      a_arr[i] = '0;
      b_arr[i] = '0;
    end
    #1;
    check_cleared("reset");
    chk("reset_state", {30'd0, state_dbg}, {30'd0, IDLE});
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    m_ptr = 0;

    // Table-driven single requests.
    for (int v = 0; v < 10; v++) begin
      a_arr[vecs[v].idx] = vecs[v].a;
      b_arr[vecs[v].idx] = vecs[v].b;
      do_op(N'(1) << vecs[v].idx, 0, 1'b0, 1'b1, vecs[v].exp, 1'b0);
    end

    // Back-pressure on requester 1 for 5 cycles.
    a_arr[1] = 16'h0019;
    b_arr[1] = 16'h0010;
    do_op(4'b0010, 5, 1'b0, 1'b1, 16'h0031, 1'b0);

    // Round robin with wrap: all valid from reset, rsp_ready held high.
    rst = 1'b1;
    #1;
    check_cleared("rr_reset");
    @(posedge clk); #1;
    rst = 1'b0;
    m_ptr = 0;
    for (int i = 0; i < N; i++) begin
      a_arr[i] = 16'($urandom);
      b_arr[i] = 16'($urandom);
    end
    for (int k = 0; k < 5; k++) begin
      chk("rr_order_model", ref_grant(4'b1111, m_ptr), k % N);
      do_op(4'b1111, 0, 1'b1, 1'b0, 16'h0, k > 0);
    end
    valid_drv = '0;

    // Reset during CALC with requester 3 granted.
    a_arr[3] = 16'h0019;
    b_arr[3] = 16'h0010;
    valid_drv = 4'b1000;
    rdy_drv   = '0;
    #1;
    chk("abort_grant3", {28'd0, bus.req_ready}, 32'h8);
    @(posedge clk); #1;
    chk("abort_in_calc", {31'd0, bus.busy}, 1);
    valid_drv = '0;
    rst = 1'b1;
    watch3 = 1'b1;
    #1;
    check_cleared("abort");
    repeat (3) @(posedge clk);
    #1;
    check_cleared("abort_hold");
    rst = 1'b0;
    m_ptr = 0;
    a_arr[1] = 16'h0047;
    b_arr[1] = 16'h0022;
    do_op(4'b1010, 0, 1'b0, 1'b1, 16'h0047, 1'b0);
    watch3 = 1'b0;
    do_op(4'b1000, 0, 1'b0, 1'b0, 16'h0, 1'b0);

    // Randomized traffic against the reference model.
    for (int t = 0; t < 40; t++) begin
      valid_drv = '0;
      for (int i = 0; i < N; i++) begin
        a_arr[i] = 16'($urandom);
        b_arr[i] = 16'($urandom);
      end
      do_op(N'($urandom_range(1, 15)), $urandom_range(0, 3), 1'b0, 1'b0, 16'h0, 1'b0);
    end
    valid_drv = '0;

    @(posedge clk); #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
